// File: rtl/photo_tape_emu.sv
// Photoelectric paper-tape reader emulator: replays a loaded frame image onto the
// PHOTO1..PHOTO5 sense lines with frame/gap timing, forward or reverse.
module photo_tape_emu #(
    parameter int DEPTH     = 256,
    parameter int FRAME_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic                     CLOCK,
    input  logic                     rst,
    input  logic                     PHOTO_TAPE_FWD,
    input  logic                     PHOTO_TAPE_REV,
    input  logic                     load_clr,
    input  logic                     load_we,
    input  logic [4:0]               load_data,
    output logic                     PHOTO1,
    output logic                     PHOTO2,
    output logic                     PHOTO3,
    output logic                     PHOTO4,
    output logic                     PHOTO5,
    output logic [$clog2(DEPTH):0]   tape_pos,
    output logic [$clog2(DEPTH):0]   tape_len,
    output logic                     at_start,
    output logic                     at_end,
    output logic                     busy,
    output logic                     load_full,
    output logic [1:0]               fsm_state
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int TMAX = (FRAME_CYC > GAP_CYC) ? FRAME_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] ONE_T      = TW'(1);
    localparam logic [PW-1:0] ONE_P      = PW'(1);
    localparam logic [AW-1:0] ONE_A      = AW'(1);
    localparam logic [PW-1:0] FULL_LEN   = PW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, GAP = 2'd2} state_t;
    typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

    state_t          state_q, state_n;
    dir_t            dir_q, dir_n;
    logic [TW-1:0]   timer_q, timer_n;
    logic [PW-1:0]   pos_q, pos_n, len_q;
    logic [4:0]      photo_q, photo_n;
    logic [PW-1:0]   pos_upd, eval_pos;
    logic [AW-1:0]   sel;
    logic            gap_last, go_fwd, go_rev, wr_en;

    logic [4:0]      image [DEPTH];

    // Drive requests are levels, not handshakes: a move starts only when exactly one
    // of FWD/REV is high at an evaluation point, and a started frame period always
    // completes in its latched direction regardless of later request changes.
    assign pos_upd  = (dir_q == REV) ? pos_q - ONE_P : pos_q + ONE_P;
    assign gap_last = (state_q == GAP) && (timer_q == GAP_LAST);
    assign eval_pos = gap_last ? pos_upd : pos_q;
    assign go_fwd   = PHOTO_TAPE_FWD && !PHOTO_TAPE_REV && (eval_pos < len_q);
    assign go_rev   = PHOTO_TAPE_REV && !PHOTO_TAPE_FWD && (eval_pos != '0);
    assign sel      = go_rev ? eval_pos[AW-1:0] - ONE_A : eval_pos[AW-1:0];

    assign load_full = (len_q == FULL_LEN);
    assign wr_en     = load_we && !load_full && !rst && !load_clr;

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        timer_n = timer_q;
        pos_n   = pos_q;
        photo_n = photo_q;
        case (state_q)
            FRAME: begin
                if (timer_q == FRAME_LAST) begin
                    state_n = GAP;
                    timer_n = '0;
                    photo_n = '0;
                end else begin
                    timer_n = timer_q + ONE_T;
                end
            end
            GAP: begin
                photo_n = '0;
                if (gap_last) begin
                    pos_n   = pos_upd;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q + ONE_T;
                end
            end
            default: begin
                photo_n = '0;
            end
        endcase
        // The last gap cycle launches the next frame exactly as IDLE would, so
        // continuous drive has no dead cycle between periods.
        if ((state_q == IDLE) || gap_last) begin
            if (go_fwd || go_rev) begin
                state_n = FRAME;
                dir_n   = go_rev ? REV : FWD;
                timer_n = '0;
                photo_n = image[sel];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= FWD;
            timer_q <= '0;
            pos_q   <= '0;
            len_q   <= '0;
            photo_q <= '0;
        end else if (load_clr) begin
            state_q <= IDLE;
            timer_q <= '0;
            pos_q   <= '0;
            len_q   <= '0;
            photo_q <= '0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            timer_q <= timer_n;
            pos_q   <= pos_n;
            photo_q <= photo_n;
            if (wr_en) begin
                len_q <= len_q + ONE_P;
            end
        end
    end

    // Image contents survive rst and load_clr; tape_len alone bounds valid data.
    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            image[len_q[AW-1:0]] <= load_data;
        end
    end

    assign PHOTO1    = photo_q[0];
    assign PHOTO2    = photo_q[1];
    assign PHOTO3    = photo_q[2];
    assign PHOTO4    = photo_q[3];
    assign PHOTO5    = photo_q[4];
    assign tape_pos  = pos_q;
    assign tape_len  = len_q;
    assign at_start  = (pos_q == '0);
    assign at_end    = (pos_q == len_q);
    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;
endmodule

// File: tb/tb_photo_tape_emu.sv
// Directed bench for photo_tape_emu: per-cycle vector table for replay timing plus
// hand sequences for reset, overflow, clear and stop corner cases.
module tb_photo_tape_emu;
    localparam int DEPTH = 256;

    logic       CLOCK = 1'b0;
    logic       rst, fwd, rev, load_clr, load_we;
    logic [4:0] load_data;
    logic       PHOTO1, PHOTO2, PHOTO3, PHOTO4, PHOTO5;
    logic [8:0] tape_pos, tape_len;
    logic       at_start, at_end, busy, load_full;
    logic [1:0] fsm_state;
    logic [4:0] photo;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       fwd;
        logic       rev;
        logic [4:0] photo;
        int         pos;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    photo_tape_emu #(.DEPTH(DEPTH), .FRAME_CYC(4), .GAP_CYC(2)) dut (
        .CLOCK(CLOCK), .rst(rst), .PHOTO_TAPE_FWD(fwd), .PHOTO_TAPE_REV(rev),
        .load_clr(load_clr), .load_we(load_we), .load_data(load_data),
        .PHOTO1(PHOTO1), .PHOTO2(PHOTO2), .PHOTO3(PHOTO3), .PHOTO4(PHOTO4), .PHOTO5(PHOTO5),
        .tape_pos(tape_pos), .tape_len(tape_len), .at_start(at_start), .at_end(at_end),
        .busy(busy), .load_full(load_full), .fsm_state(fsm_state)
    );

    assign photo = {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1};

    // clock / reset
    always #5 CLOCK = ~CLOCK;

    // driver tasks
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic load(input logic [4:0] d);
        load_we   = 1'b1;
        load_data = d;
        step();
        load_we   = 1'b0;
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void add(input int n, input logic f, input logic r,
                                input logic [4:0] p, input int pos, input logic b);
        vec_t v;
        v.fwd = f; v.rev = r; v.photo = p; v.pos = pos; v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; fwd = 1'b0; rev = 1'b0; load_clr = 1'b0; load_we = 1'b0; load_data = '0;

        // forward through 01,1F,10 then end-of-tape stop
        add(4, 1, 0, 5'h01, 0, 1); add(2, 1, 0, 5'h00, 0, 1);
        add(4, 1, 0, 5'h1F, 1, 1); add(2, 1, 0, 5'h00, 1, 1);
        add(4, 1, 0, 5'h10, 2, 1); add(2, 1, 0, 5'h00, 2, 1);
        add(3, 1, 0, 5'h00, 3, 0);
        // reverse back to the start
        add(4, 0, 1, 5'h10, 3, 1); add(2, 0, 1, 5'h00, 3, 1);
        add(4, 0, 1, 5'h1F, 2, 1); add(2, 0, 1, 5'h00, 2, 1);
        add(4, 0, 1, 5'h01, 1, 1); add(2, 0, 1, 5'h00, 1, 1);
        add(3, 0, 1, 5'h00, 0, 0);
        // forward dropped in frame cycle 2: frame and gap coast to completion
        add(2, 1, 0, 5'h01, 0, 1); add(2, 0, 0, 5'h01, 0, 1);
        add(2, 0, 0, 5'h00, 0, 1); add(2, 0, 0, 5'h00, 1, 0);
        // both requests high is a stop
        add(10, 1, 1, 5'h00, 1, 0);

        repeat (2) step();
        rst = 1'b0;
        step();
        chk("reset_photo", photo, 0);
        chk("reset_pos", tape_pos, 0);
        chk("reset_len", tape_len, 0);
        chk("reset_busy", busy, 0);
        chk("reset_at_start", at_start, 1);
        chk("reset_at_end", at_end, 1);
        chk("reset_full", load_full, 0);
        chk("reset_state", fsm_state, 0);

        load(5'h01); load(5'h1F); load(5'h10);
        chk("load3_len", tape_len, 3);
        chk("load3_at_end", at_end, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            fwd = vecs[i].fwd;
            rev = vecs[i].rev;
            step();
            chk($sformatf("vec%0d_photo", i), photo, vecs[i].photo);
            chk($sformatf("vec%0d_pos", i), tape_pos, vecs[i].pos);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_at_start", i), at_start, vecs[i].pos == 0);
            chk($sformatf("vec%0d_at_end", i), at_end, vecs[i].pos == 3);
        end

        // reset mid-frame at tape_pos 2
        fwd = 1'b1; rev = 1'b0;
        repeat (8) step();
        chk("pre_rst_pos", tape_pos, 2);
        chk("pre_rst_photo", photo, 5'h10);
        rst = 1'b1;
        step();
        rst = 1'b0; fwd = 1'b0;
        chk("rst_mid_pos", tape_pos, 0);
        chk("rst_mid_len", tape_len, 0);
        chk("rst_mid_photo", photo, 0);
        chk("rst_mid_busy", busy, 0);

        // overflow: DEPTH+1 writes, last one dropped
        for (int i = 0; i <= DEPTH; i++) begin
            logic [4:0] d;
            d = 5'(i) ^ 5'h15;
            load(d);
        end
        chk("full_len", tape_len, DEPTH);
        chk("full_flag", load_full, 1);
        fwd = 1'b1;
        step();
        chk("full_frame0", photo, 5'h15);
        chk("full_busy", busy, 1);

        // load_clr mid-frame overrides load_we and the move
        fwd = 1'b0; load_clr = 1'b1; load_we = 1'b1; load_data = 5'h07;
        step();
        load_clr = 1'b0; load_we = 1'b0;
        chk("clr_len", tape_len, 0);
        chk("clr_pos", tape_pos, 0);
        chk("clr_photo", photo, 0);
        chk("clr_busy", busy, 0);
        chk("clr_full", load_full, 0);

        // empty tape: forward request is an end-of-tape stop
        fwd = 1'b1;
        repeat (3) step();
        chk("empty_busy", busy, 0);
        chk("empty_photo", photo, 0);
        fwd = 1'b0;

        load(5'h0A);
        chk("reload_len", tape_len, 1);
        fwd = 1'b1;
        step();
        chk("reload_frame", photo, 5'h0A);
        repeat (6) step();
        chk("reload_pos", tape_pos, 1);
        chk("reload_at_end", at_end, 1);
        chk("reload_busy", busy, 0);
        fwd = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
